// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - writeback queue feeding the single register file write port
// Buffers ALU/LSU results in a FIFO, extends load data, drains one entry per cycle.
module wb_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [1:0]      lsu_addr_lo_i,
  input  logic            wb_hold_i,
  output logic            wen_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] result_o,
  output logic [31:0]     busy_mask_o,
  output logic            empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic             wen_q, wen_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [4:0]       rd_mem_q   [DEPTH];
  logic [XLEN-1:0]  data_mem_q [DEPTH];

  logic             full, push_hs, push_en, pop;
  logic [4:0]       push_rd;
  logic [XLEN-1:0]  push_data, load_data, byte_lane, half_lane;
  logic [AW-1:0]    offs;
  logic [31:0]      busy;

  // A pop in the same cycle never frees a slot: full comes straight from the register.
  assign full        = (count_q == (AW+1)'(DEPTH));
  assign lsu_ready_o = !full;
  assign alu_ready_o = !full && !lsu_valid_i;
  assign push_hs     = (lsu_valid_i && lsu_ready_o) || (alu_valid_i && alu_ready_o);
  assign push_rd     = lsu_valid_i ? lsu_rd_i : alu_rd_i;
  assign push_data   = lsu_valid_i ? load_data : alu_data_i;
  assign push_en     = push_hs && (push_rd != 5'd0);
  assign pop         = (count_q != '0) && !wb_hold_i;

  always_comb begin
    byte_lane = lsu_data_i >> {lsu_addr_lo_i, 3'b000};
    half_lane = lsu_data_i >> {lsu_addr_lo_i[1], 4'b0000};
    case (lsu_funct3_i)
      3'b000:  load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane[7:0]};
      3'b001:  load_data = {{(XLEN-16){half_lane[15]}}, half_lane[15:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_lane[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, half_lane[15:0]};
      default: load_data = lsu_data_i;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    wen_d    = pop;
    rd_d     = rd_q;
    result_d = result_q;
    if (push_en) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d   = rptr_q + 1'b1;
      rd_d     = rd_mem_q[rptr_q];
      result_d = data_mem_q[rptr_q];
    end
    case ({push_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    busy = '0;
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - rptr_q;
      if ({1'b0, offs} < count_q) begin
        busy[rd_mem_q[i]] = 1'b1;
      end
    end
    if (wen_q) begin
      busy[rd_q] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      wen_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      count_q  <= count_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      wen_q    <= wen_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      rd_mem_q[wptr_q]   <= push_rd;
      data_mem_q[wptr_q] <= push_data;
    end
  end

  assign wen_o       = wen_q;
  assign rd_o        = rd_q;
  assign result_o    = result_q;
  assign busy_mask_o = busy;
  assign empty_o     = (count_q == '0) && !wen_q;

endmodule
